// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_e - controller states (RUN, MEM_WAIT)
//   ctrl_t  - pipeline-register / PC control bundle
//   resolve_run() - jump / load-use priority used in RUN and on freeze release
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_clear;
    logic exmem_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                    idex_en: 1'b1, idex_clear: 1'b0, exmem_en: 1'b1};
  localparam ctrl_t CTRL_OFF    = '0;

  // A taken jump outranks a load-use bubble: the dependent instruction is
  // flushed anyway, so its stall would only waste a cycle.
  function automatic ctrl_t resolve_run(input logic jump, input logic lu);
    ctrl_t c;
    c = CTRL_NORMAL;
    if (jump) begin
      c.ifid_flush = 1'b1;
      c.idex_clear = 1'b1;
    end else if (lu) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_clear = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// hazard_if: bundles the hazard controller's pipeline-facing signals.
//   Inputs to the controller: ID source regs and valids, ID/EX dest/load flag,
//   EX jump resolution, MEM memory/vector flags, counter clear.
//   Outputs from the controller: PC / IF/ID / ID/EX / EX/MEM controls, busy,
//   stall_cycles.
//   master: the pipeline side; slave: the controller.
interface hazard_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rs3;
  logic [2:0]        id_rs_used;
  logic [REG_AW-1:0] idex_rr;
  logic              idex_memread;
  logic              ex_jump_taken;
  logic              exmem_mem;
  logic              exmem_vector;
  logic              cnt_clr;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_clear;
  logic              exmem_en;
  logic              busy;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs3, id_rs_used, idex_rr, idex_memread,
           ex_jump_taken, exmem_mem, exmem_vector, cnt_clr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en,
           busy, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs3, id_rs_used, idex_rr, idex_memread,
           ex_jump_taken, exmem_mem, exmem_vector, cnt_clr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en,
           busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst (async, active-low), inc, clr (has priority), count.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller. Produces PC / IF/ID / ID/EX /
// EX/MEM enables and clears for load-use bubbles, taken-jump flushes and
// multi-cycle vector memory freezes, and counts cycles the PC is held.
//   clk  - state updates on posedge; outputs are Mealy and settle by negedge
//   rst  - asynchronous, active-low
//   hif  - hazard_if slave: pipeline status in, controls/busy/stall_cycles out
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned MEM_LAT    = 4,
  parameter bit          R0_IS_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic      clk,
  input  logic      rst,
  hazard_if.slave   hif
);

  localparam bit          FREEZE_EN = (MEM_LAT > 1);
  localparam int unsigned WCW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int unsigned WAIT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  ctrl_t            ctrl;
  logic             busy;
  logic             trig;
  logic             lu;
  logic [REG_AW-1:0] rs [3];

  assign rs[0] = hif.id_rs1;
  assign rs[1] = hif.id_rs2;
  assign rs[2] = hif.id_rs3;

  assign trig = FREEZE_EN & hif.exmem_mem & hif.exmem_vector;

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (hif.id_rs_used[i] && (rs[i] == hif.idex_rr))
        lu = 1'b1;
    end
    if (R0_IS_ZERO && (hif.idex_rr == '0))
      lu = 1'b0;
    lu = lu & hif.idex_memread;
  end

  // The trigger cycle in RUN counts as the first frozen cycle, so wait_cnt
  // starts at MEM_LAT-2 and the release cycle (wait_cnt==0) ignores trig to
  // avoid re-freezing on the departing op.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_NORMAL;
    busy       = 1'b0;
    case (state_q)
      RUN: begin
        if (trig) begin
          ctrl       = CTRL_OFF;
          busy       = 1'b1;
          wait_cnt_d = WCW'(WAIT_INIT);
          state_d    = MEM_WAIT;
        end else begin
          ctrl = resolve_run(hif.ex_jump_taken, lu);
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q != '0) begin
          ctrl       = CTRL_OFF;
          busy       = 1'b1;
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end else begin
          ctrl    = resolve_run(hif.ex_jump_taken, lu);
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // Pipeline registers must not load while reset is held.
    if (!rst) begin
      ctrl = CTRL_OFF;
      busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign hif.pc_en      = ctrl.pc_en;
  assign hif.ifid_en    = ctrl.ifid_en;
  assign hif.ifid_flush = ctrl.ifid_flush;
  assign hif.idex_en    = ctrl.idex_en;
  assign hif.idex_clear = ctrl.idex_clear;
  assign hif.exmem_en   = ctrl.exmem_en;
  assign hif.busy       = busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_en),
    .clr   (hif.cnt_clr),
    .count (hif.stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned CNT_W  = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en, busy}
  localparam logic [6:0] O_NORM = 7'b1101010;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_JMP  = 7'b1111110;
  localparam logic [6:0] O_FRZ  = 7'b0000001;
  localparam logic [6:0] O_OFF  = 7'b0000000;

  typedef struct {
    string             name;
    logic [REG_AW-1:0] rs1, rs2, rs3;
    logic [2:0]        used;
    logic [REG_AW-1:0] rr;
    logic              memread, jump, mem, vec;
    logic [6:0]        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl [9];

  hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.REG_AW(REG_AW), .MEM_LAT(4), .R0_IS_ZERO(1'b1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
            hif.idex_clear, hif.exmem_en, hif.busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_rs3 = '0; hif.id_rs_used = '0;
    hif.idex_rr = '0; hif.idex_memread = 1'b0; hif.ex_jump_taken = 1'b0;
    hif.exmem_mem = 1'b0; hif.exmem_vector = 1'b0; hif.cnt_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hif.id_rs1 = v.rs1; hif.id_rs2 = v.rs2; hif.id_rs3 = v.rs3;
    hif.id_rs_used = v.used; hif.idex_rr = v.rr; hif.idex_memread = v.memread;
    hif.ex_jump_taken = v.jump; hif.exmem_mem = v.mem; hif.exmem_vector = v.vec;
  endtask

  task automatic clear_cnt();
    idle();
    hif.cnt_clr = 1'b1;
    tick();
    hif.cnt_clr = 1'b0;
  endtask

  task automatic set_lu();
    idle();
    hif.idex_memread = 1'b1; hif.idex_rr = 4'd5;
    hif.id_rs2 = 4'd5; hif.id_rs_used = 3'b010;
  endtask

  initial begin
    //          name        rs1   rs2   rs3   used    rr    mrd  jmp  mem  vec  exp
    tbl[0] = '{"lu_rs2",    4'd0, 4'd5, 4'd0, 3'b010, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[1] = '{"lu_r0",     4'd0, 4'd0, 4'd0, 3'b010, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[2] = '{"lu_unused", 4'd0, 4'd5, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[3] = '{"lu_rs3",    4'd1, 4'd2, 4'd7, 3'b100, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[4] = '{"no_load",   4'd5, 4'd0, 4'd0, 3'b001, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
    tbl[5] = '{"jmp_lu",    4'd5, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_JMP};
    tbl[6] = '{"jmp",       4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_JMP};
    tbl[7] = '{"scalar_mem",4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_NORM};
    tbl[8] = '{"lu_rs1_all",4'd9, 4'd3, 4'd2, 3'b111, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};

    idle();
    rst = 1'b0;
    #3;
    check("reset_outs", 32'(outs()), 32'(O_OFF));
    check("reset_cnt", 32'(hif.stall_cycles), 32'd0);
    tick();
    rst = 1'b1;

    // Single-cycle RUN vectors; three of them stall the PC.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      #2;
      check(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
      tick();
    end
    idle();
    check("tbl_stall_cnt", 32'(hif.stall_cycles), 32'd3);

    clear_cnt();
    check("cnt_clr", 32'(hif.stall_cycles), 32'd0);

    // Load-use bubble, then the bubble has cleared idex_memread.
    set_lu();
    #2; check("lu_seq_stall", 32'(outs()), 32'(O_LU));
    tick();
    hif.idex_memread = 1'b0;
    #2; check("lu_seq_next", 32'(outs()), 32'(O_NORM));
    tick();
    check("lu_seq_cnt", 32'(hif.stall_cycles), 32'd1);

    // Vector memory freeze, back-to-back with a second op.
    clear_cnt();
    hif.exmem_mem = 1'b1; hif.exmem_vector = 1'b1;
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < 3; k++) begin
        #2; check($sformatf("frz%0d_c%0d", op, k), 32'(outs()), 32'(O_FRZ));
        tick();
      end
      #2; check($sformatf("frz%0d_rel", op), 32'(outs()), 32'(O_NORM));
      tick();
    end
    idle();
    #2; check("frz_after", 32'(outs()), 32'(O_NORM));
    check("frz_cnt", 32'(hif.stall_cycles), 32'd6);

    // Jump pending through a freeze: flushed only on release.
    clear_cnt();
    hif.exmem_mem = 1'b1; hif.exmem_vector = 1'b1; hif.ex_jump_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2; check($sformatf("frzj_c%0d", k), 32'(outs()), 32'(O_FRZ));
      tick();
    end
    #2; check("frzj_rel", 32'(outs()), 32'(O_JMP));
    tick();
    idle();

    // Reset in MEM_WAIT with wait_cnt=1.
    hif.exmem_mem = 1'b1; hif.exmem_vector = 1'b1;
    tick();
    tick();
    #2; check("rstmid_frozen", 32'(outs()), 32'(O_FRZ));
    rst = 1'b0;
    #1; check("rstmid_outs", 32'(outs()), 32'(O_OFF));
    idle();
    #1; rst = 1'b1;
    #1; check("rstmid_norm", 32'(outs()), 32'(O_NORM));
    check("rstmid_cnt", 32'(hif.stall_cycles), 32'd0);
    tick();
    #2; check("rstmid_run", 32'(outs()), 32'(O_NORM));

    // Saturation and clear-over-increment.
    clear_cnt();
    set_lu();
    repeat (20) tick();
    check("sat_cnt", 32'(hif.stall_cycles), 32'd15);
    hif.cnt_clr = 1'b1;
    tick();
    check("sat_clr", 32'(hif.stall_cycles), 32'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the vector core. It generates the enable and clear controls for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It covers three cases:
- load-use bubbles;
- taken-jump flushes (JumpI/JumpCI/JumpCD resolved in EX);
- multi-cycle freezes for vector memory accesses in MEM.

It sits beside the pipeline registers; no datapath passes through it.

Parameters:
REG_AW, 4, register address width (matches RR fields).
MEM_LAT, 4, total cycles a vector memory op occupies MEM (>=1; 1 means no freeze).
R0_IS_ZERO, 1, when 1, source/dest register 0 never raises a load-use hazard.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock; state updates on posedge, pipeline registers sample outputs on negedge.
rst  in  1  asynchronous, active-low reset.
id_rs1, id_rs2, id_rs3  in  REG_AW each  source register addresses of the instruction in ID.
id_rs_used  in  3  per-source valid bits {rs3, rs2, rs1}.
idex_rr  in  REG_AW  destination register of the instruction in EX (ID/EX RR_out).
idex_memread  in  1  instruction in EX is a load (ID/EX MemRead_out).
ex_jump_taken  in  1  jump resolved taken in EX this cycle.
exmem_mem  in  1  instruction in MEM performs MemRead or MemWrite.
exmem_vector  in  1  that memory instruction is a vector op.
cnt_clr  in  1  synchronous clear of stall_cycles.
pc_en  out  1  PC may update.
ifid_en  out  1  IF/ID may load.
ifid_flush  out  1  IF/ID loads zero.
idex_en  out  1  ID/EX may load.
idex_clear  out  1  ID/EX loads zero (bubble/flush).
exmem_en  out  1  EX/MEM and MEM/WB may load.
busy  out  1  memory freeze in progress.
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, wait_cnt=0, stall_cycles=0.
  - Outputs: pc_en=ifid_en=idex_en=exmem_en=0; ifid_flush=idex_clear=0; busy=0.
  - Reset mid-freeze abandons the freeze with no residual state.
- States: RUN, MEM_WAIT. Outputs are Mealy, combinational from state and inputs, and settle before the negedge.
- trig = exmem_mem & exmem_vector & (MEM_LAT>1).
- lu = idex_memread & any i: id_rs_used[i] & (id_rsi==idex_rr) & !(R0_IS_ZERO & idex_rr==0).
- Default (normal) outputs: all enables=1, flush/clear=0.
- Priority in RUN:
  1. trig:
     - Outputs: all enables=0, busy=1.
     - wait_cnt <= MEM_LAT-2; next state MEM_WAIT.
  2. ex_jump_taken:
     - Outputs: ifid_flush=1, idex_clear=1, pc_en=1 (PC takes target), others normal.
     - The lu result is discarded.
  3. lu:
     - Outputs: pc_en=0, ifid_en=0, idex_clear=1, exmem_en=1.
     - Exactly one bubble. No state is needed, because the bubble clears idex_memread the next cycle.
  4. Otherwise: normal outputs.
- MEM_WAIT:
  - While wait_cnt!=0: all enables=0, busy=1, flush/clear=0, wait_cnt decrements. ex_jump_taken and lu are ignored (inputs are frozen).
  - When wait_cnt==0 (release cycle): busy=0; outputs evaluated as RUN priorities 2-4 with trig masked; next state RUN. This prevents re-triggering on the departing op.
- Freeze length: exactly MEM_LAT-1 cycles with exmem_en=0 per vector memory op.
- Back-to-back vector memory ops each freeze independently.
- stall_cycles: increments every posedge where pc_en=0 and rst=1; saturates at all-ones; cnt_clr has priority over increment.
- Scalar memory ops (exmem_vector=0) never freeze.

Decomposition:
- Package hazard_pkg: state enum {RUN, MEM_WAIT}, REG_AW default, control-output struct (pc_en..exmem_en).
- Sub-module sat_counter (CNT_W, inc, clr, async active-low reset) for stall_cycles.
- Load-use comparator stays inline.

Test Plan:
- Reset: rst=0 mid-MEM_WAIT (wait_cnt=1) -> outputs immediately 0/0/0; after release, state=RUN, stall_cycles=0, normal outputs.
- Load-use: idex_memread=1, idex_rr=5, id_rs2=5, id_rs_used=3'b010 -> one cycle pc_en=0, ifid_en=0, idex_clear=1; next cycle (idex_memread=0) normal; stall_cycles=1. Same with idex_rr=0 -> no stall.
- Jump+load-use same cycle: ex_jump_taken=1 and lu=1 -> ifid_flush=1, idex_clear=1, pc_en=1, ifid_en=1.
- Vector memory freeze, MEM_LAT=4: exmem_mem=1, exmem_vector=1 held -> 3 cycles with all enables=0 and busy=1, then 1 release cycle of normal outputs, no re-trigger; stall_cycles=3.
- Freeze with pending jump: ex_jump_taken=1 throughout the freeze -> no flush during the 3 frozen cycles; flush asserted in the release cycle.
- Saturation/clear, CNT_W=4: 20 stall cycles -> stall_cycles=15; cnt_clr=1 together with a stall -> 0.
